parking_lot_multi_gate: RTL

Multi-gate parking-lot occupancy counter: each of `N_GATES` gates has an A/B beam-sensor pair and a direction-decoding FSM that emits one entry or exit event per completed vehicle passage. A shared saturating counter tracks occupancy up to `CAPACITY` and drives full, empty, overflow and underflow status. It replaces the single-gate 3-bit counter as the top-level occupancy block and adds several gates, a configurable capacity, abort and illegal-sequence handling, and sticky error flags.

---
 rtl/parking_lot_multi_gate.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/parking_lot_multi_gate.sv
// Multi-gate parking-lot occupancy counter with per-gate direction FSMs.
// Optional PARKING_SENSOR_SYNC_EN adds a 2-flop sensor synchronizer.
module parking_lot_multi_gate #(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 7,
    localparam int CW      = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] sensor_a,
    input  logic [N_GATES-1:0] sensor_b,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [N_GATES-1:0] entry_pulse,
    output logic [N_GATES-1:0] exit_pulse,
    output logic [N_GATES-1:0] seq_err,
    output logic               overflow,
    output logic               underflow
);

    localparam int SW = CW + 4;
    localparam logic [CW-1:0]        CAP_C = CW'(CAPACITY);
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN1,
        S_IN2,
        S_IN3,
        S_OUT1,
        S_OUT2,
        S_OUT3,
        S_ERR
    } state_e;

    logic [N_GATES-1:0] sa;
    logic [N_GATES-1:0] sb;

`ifdef PARKING_SENSOR_SYNC_EN
    logic [N_GATES-1:0] a_s1_q, a_s1_d;
    logic [N_GATES-1:0] a_s2_q, a_s2_d;
    logic [N_GATES-1:0] b_s1_q, b_s1_d;
    logic [N_GATES-1:0] b_s2_q, b_s2_d;

    always_comb begin
        a_s1_d = sensor_a;
        a_s2_d = a_s1_q;
        b_s1_d = sensor_b;
        b_s2_d = b_s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
        end else begin
            a_s1_q <= a_s1_d;
            a_s2_q <= a_s2_d;
            b_s1_q <= b_s1_d;
            b_s2_q <= b_s2_d;
        end
    end

    assign sa = a_s2_q;
    assign sb = b_s2_q;
`else
    assign sa = sensor_a;
    assign sb = sensor_b;
`endif

    state_e             state_q [N_GATES];
    state_e             state_d [N_GATES];
    logic [N_GATES-1:0] entry_q, entry_d;
    logic [N_GATES-1:0] exit_q, exit_d;
    logic [N_GATES-1:0] err_q, err_d;

    always_comb begin
        logic [1:0] ab;
        entry_d = '0;
        exit_d  = '0;
        err_d   = err_q;
        ab      = 2'b00;
        for (int g = 0; g < N_GATES; g++) begin
            state_d[g] = state_q[g];
            ab = {sa[g], sb[g]};
            case (state_q[g])
                S_IDLE: begin
                    case (ab)
                        2'b10:   state_d[g] = S_IN1;
                        2'b01:   state_d[g] = S_OUT1;
                        2'b11:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_IN1: begin
                    case (ab)
                        2'b11:   state_d[g] = S_IN2;
                        2'b00:   state_d[g] = S_IDLE;
                        2'b01:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_IN2: begin
                    case (ab)
                        2'b01:   state_d[g] = S_IN3;
                        2'b10:   state_d[g] = S_IN1;
                        2'b00:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_IN3: begin
                    case (ab)
                        2'b00: begin
                            state_d[g] = S_IDLE;
                            entry_d[g] = 1'b1;
                        end
                        2'b11:   state_d[g] = S_IN2;
                        2'b10:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_OUT1: begin
                    case (ab)
                        2'b11:   state_d[g] = S_OUT2;
                        2'b00:   state_d[g] = S_IDLE;
                        2'b10:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_OUT2: begin
                    case (ab)
                        2'b10:   state_d[g] = S_OUT3;
                        2'b01:   state_d[g] = S_OUT1;
                        2'b00:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                S_OUT3: begin
                    case (ab)
                        2'b00: begin
                            state_d[g] = S_IDLE;
                            exit_d[g]  = 1'b1;
                        end
                        2'b11:   state_d[g] = S_OUT2;
                        2'b01:   state_d[g] = S_ERR;
                        default: ;
                    endcase
                end
                default: begin
                    if (ab == 2'b00) state_d[g] = S_IDLE;
                end
            endcase
            if (state_d[g] == S_ERR) err_d[g] = 1'b1;
        end
    end

    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [SW-1:0]        e_cnt;
    logic [SW-1:0]        x_cnt;
    logic signed [SW-1:0] next_s;

    // Net change from all gates is applied in one step so simultaneous
    // entry/exit cancel before any clamping.
    always_comb begin
        e_cnt = '0;
        x_cnt = '0;
        for (int g = 0; g < N_GATES; g++) begin
            e_cnt = e_cnt + SW'(entry_q[g]);
            x_cnt = x_cnt + SW'(exit_q[g]);
        end
        next_s  = $signed(SW'(count_q)) + $signed(e_cnt)
                - $signed(x_cnt);
        count_d = next_s[CW-1:0];
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (next_s > CAP_S) begin
            count_d = CAP_C;
            ovf_d   = 1'b1;
        end else if (next_s[SW-1]) begin
            count_d = '0;
            unf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < N_GATES; g++) state_q[g] <= S_IDLE;
            entry_q <= '0;
            exit_q  <= '0;
            err_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            for (int g = 0; g < N_GATES; g++) state_q[g] <= state_d[g];
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count       = count_q;
    assign full        = (count_q == CAP_C);
    assign empty       = (count_q == '0);
    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign seq_err     = err_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
